// File: rtl/count_sequencer.sv
// count_sequencer: run controller for the T-flip-flop counter chain.
// Produces a prescaled one-cycle count-enable (En), holds the count (Q) and
// runs an IDLE/RUN/PAUSE/DONE state machine against a live terminal value.
//
// Optional build macro: COUNT_SEQ_AUTO_RELOAD_EN
//   undefined (default): the terminating tick parks the machine in DONE until
//                        Start or Clr.
//   defined            : the terminating tick reloads Q=0, stays in RUN and
//                        pulses Done for one cycle.
//
// A pause only costs the cycles in which Pause is sampled high: the cycle in
// which the machine leaves PAUSE already advances the prescaler (and may
// tick), so the prescaler phase carries straight across the pause.
module count_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Start,
    input  logic             Pause,
    input  logic [WIDTH-1:0] Term,
    output logic             En,
    output logic [WIDTH-1:0] Q,
    output logic [1:0]       State,
    output logic             Busy,
    output logic             Done
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PRE_LAST = PS_W'(PRESCALE - 1);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("count_sequencer: PRESCALE must be 1 or more");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  q_next_s;
    logic [WIDTH-1:0]  q_plus1_s;
    logic [PS_W-1:0]   pre_r;
    logic [PS_W-1:0]   pre_next_s;
    logic              busy_r;
    logic              busy_next_s;
    logic              done_r;
    logic              done_next_s;
    logic              tick_s;
    logic              hit_s;

    // Next-state, next-count, prescaler and tick decode from registered state.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        pre_next_s   = pre_r;
        tick_s       = 1'b0;
        hit_s        = 1'b0;
        q_plus1_s    = q_r + WIDTH'(1);

        case (state_r)
            IDLE, DONE: begin
                // Pause is ignored here; Start (re)launches a run.
                if (Start) begin
                    q_next_s   = '0;
                    pre_next_s = '0;
                    if (Term != '0) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN, PAUSE: begin
                // Start is ignored while a run is in progress.
                if (Pause) begin
                    state_next_s = PAUSE;
                end else begin
                    state_next_s = RUN;
                    if (pre_r == PRE_LAST) begin
                        tick_s     = 1'b1;
                        pre_next_s = '0;
                        q_next_s   = q_plus1_s;
                        if (q_plus1_s == Term) begin
                            hit_s = 1'b1;
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                            q_next_s = '0;
`else
                            state_next_s = DONE;
`endif
                        end else begin
                            hit_s = 1'b0;
                        end
                    end else begin
                        pre_next_s = pre_r + PS_W'(1);
                    end
                end
            end
            default: begin
                state_next_s = IDLE;
                q_next_s     = '0;
                pre_next_s   = '0;
            end
        endcase

        busy_next_s = (state_next_s == RUN) || (state_next_s == PAUSE);
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        done_next_s = (state_next_s == DONE) || hit_s;
`else
        done_next_s = (state_next_s == DONE);
`endif
    end

    // State, count, prescaler and registered status outputs; Clr has priority.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_r <= IDLE;
            q_r     <= '0;
            pre_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            pre_r   <= pre_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    assign En    = tick_s;
    assign Q     = q_r;
    assign State = state_r;
    assign Busy  = busy_r;
    assign Done  = done_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: three instances (PRESCALE 4, 1, 2)
// share one clock. Stimulus drives inputs just after each rising edge and
// pushes the outputs expected for that cycle; a negedge monitor pops and
// compares them.
module tb_count_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct {
        int         sel;
        string      name;
        logic       en;
        logic [7:0] q;
        logic [1:0] st;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk;
    logic       start_a [3];
    logic       pause_a [3];
    logic       clr_a   [3];
    logic [7:0] term_a  [3];
    logic       en_a    [3];
    logic [7:0] q_a     [3];
    logic [1:0] st_a    [3];
    logic       busy_a  [3];
    logic       done_a  [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    count_sequencer #(.WIDTH(8), .PRESCALE(4)) u_p4 (
        .Clk(clk), .Clr(clr_a[0]), .Start(start_a[0]), .Pause(pause_a[0]),
        .Term(term_a[0]), .En(en_a[0]), .Q(q_a[0]), .State(st_a[0]),
        .Busy(busy_a[0]), .Done(done_a[0]));

    count_sequencer #(.WIDTH(8), .PRESCALE(1)) u_p1 (
        .Clk(clk), .Clr(clr_a[1]), .Start(start_a[1]), .Pause(pause_a[1]),
        .Term(term_a[1]), .En(en_a[1]), .Q(q_a[1]), .State(st_a[1]),
        .Busy(busy_a[1]), .Done(done_a[1]));

    count_sequencer #(.WIDTH(8), .PRESCALE(2)) u_p2 (
        .Clk(clk), .Clr(clr_a[2]), .Start(start_a[2]), .Pause(pause_a[2]),
        .Term(term_a[2]), .En(en_a[2]), .Q(q_a[2]), .State(st_a[2]),
        .Busy(busy_a[2]), .Done(done_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int sel, input logic st, input logic pa,
                       input logic cl, input logic [7:0] tm);
        start_a[sel] = st;
        pause_a[sel] = pa;
        clr_a[sel]   = cl;
        term_a[sel]  = tm;
    endtask

    task automatic exp_out(input int sel, input string nm, input logic en,
                           input logic [7:0] q, input logic [1:0] st,
                           input logic dn);
        exp_t r;
        r.sel  = sel;
        r.name = nm;
        r.en   = en;
        r.q    = q;
        r.st   = st;
        r.busy = (st == S_RUN) || (st == S_PAUSE);
        r.done = dn;
        sb.push_back(r);
    endtask

    // Monitor: compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t r;
            r = sb.pop_front();
            checks++;
            if (en_a[r.sel] !== r.en || q_a[r.sel] !== r.q ||
                st_a[r.sel] !== r.st || busy_a[r.sel] !== r.busy ||
                done_a[r.sel] !== r.done) begin
                errors++;
                $display("FAIL %s (dut %0d): got en=%b q=%0d st=%0d busy=%b done=%b, want en=%b q=%0d st=%0d busy=%b done=%b",
                         r.name, r.sel, en_a[r.sel], q_a[r.sel], st_a[r.sel],
                         busy_a[r.sel], done_a[r.sel], r.en, r.q, r.st,
                         r.busy, r.done);
            end
        end
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            drv(s, 1'b0, 1'b0, 1'b1, 8'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            exp_out(s, "reset", 1'b0, 8'd0, S_IDLE, 1'b0);
        end

        // Test 1: PRESCALE=4, Term=3, Start sampled at edge 0.
        drv(0, 1'b1, 1'b0, 1'b0, 8'd3);
        for (int k = 0; k < 32; k++) begin
            nxt();
            drv(0, 1'b0, 1'b0, 1'b0, 8'd3);
            if (k < 12) exp_out(0, "t1_run", (k % 4) == 3, 8'(k / 4), S_RUN, 1'b0);
            else        exp_out(0, "t1_done", 1'b0, 8'd3, S_DONE, 1'b1);
        end

        // Test 2: restart from DONE, Pause sampled high at edges 6..10.
        drv(0, 1'b1, 1'b0, 1'b0, 8'd3);
        for (int k = 0; k < 21; k++) begin
            nxt();
            drv(0, 1'b0, (k >= 5 && k <= 9), 1'b0, 8'd3);
            if (k <= 5)       exp_out(0, "t2_run", (k % 4) == 3, 8'(k / 4), S_RUN, 1'b0);
            else if (k <= 10) exp_out(0, "t2_pause", 1'b0, 8'd1, S_PAUSE, 1'b0);
            else if (k <= 16) exp_out(0, "t2_resume", ((k - 5) % 4) == 3, 8'((k - 5) / 4), S_RUN, 1'b0);
            else              exp_out(0, "t2_done", 1'b0, 8'd3, S_DONE, 1'b1);
        end

        // Test 3: Term=0 from IDLE goes straight to DONE with no En.
        drv(0, 1'b0, 1'b0, 1'b1, 8'd0);
        nxt();
        exp_out(0, "t3_idle", 1'b0, 8'd0, S_IDLE, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            drv(0, 1'b0, 1'b0, 1'b0, 8'd0);
            exp_out(0, "t3_done", 1'b0, 8'd0, S_DONE, 1'b1);
        end

        // Test 5: Clr at edge 7 mid-run with Start held high.
        drv(0, 1'b0, 1'b0, 1'b1, 8'd3);
        nxt();
        exp_out(0, "t5_clr0", 1'b0, 8'd0, S_IDLE, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b0, 8'd3);
        for (int k = 0; k < 7; k++) begin
            nxt();
            drv(0, 1'b1, 1'b0, (k == 6), 8'd3);
            exp_out(0, "t5_run", (k % 4) == 3, 8'(k / 4), S_RUN, 1'b0);
        end
        nxt();
        exp_out(0, "t5_clr_mid", 1'b0, 8'd0, S_IDLE, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b0, 8'd3);
        nxt();
        exp_out(0, "t5_rerun", 1'b0, 8'd0, S_RUN, 1'b0);
        drv(0, 1'b0, 1'b1, 1'b0, 8'd3);
        nxt();
        exp_out(0, "t5_pause", 1'b0, 8'd0, S_PAUSE, 1'b0);
        drv(0, 1'b0, 1'b1, 1'b1, 8'd3);
        nxt();
        exp_out(0, "t5_clr_pause", 1'b0, 8'd0, S_IDLE, 1'b0);
        drv(0, 1'b0, 1'b0, 1'b0, 8'd3);

        // Test 4: PRESCALE=1, Term=5 to DONE, then Term=2 restart.
        drv(1, 1'b1, 1'b0, 1'b0, 8'd5);
        for (int k = 0; k < 10; k++) begin
            nxt();
            if (k == 5)     drv(1, 1'b1, 1'b0, 1'b0, 8'd2);
            else if (k < 5) drv(1, 1'b0, 1'b0, 1'b0, 8'd5);
            else            drv(1, 1'b0, 1'b0, 1'b0, 8'd2);
            if (k < 5)       exp_out(1, "t4_run5", 1'b1, 8'(k), S_RUN, 1'b0);
            else if (k == 5) exp_out(1, "t4_done5", 1'b0, 8'd5, S_DONE, 1'b1);
            else if (k < 8)  exp_out(1, "t4_run2", 1'b1, 8'(k - 6), S_RUN, 1'b0);
            else             exp_out(1, "t4_done2", 1'b0, 8'd2, S_DONE, 1'b1);
        end

        // Test 6: PRESCALE=2, Term=2; auto-reload when the macro is set.
        drv(2, 1'b1, 1'b0, 1'b0, 8'd2);
        for (int k = 0; k < 13; k++) begin
            nxt();
            drv(2, 1'b0, 1'b0, 1'b0, 8'd2);
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
            exp_out(2, "t6_reload", (k % 2) == 1, 8'((k / 2) % 2), S_RUN,
                    (k > 0) && ((k % 4) == 0));
`else
            if (k < 4) exp_out(2, "t6_run", (k % 2) == 1, 8'(k / 2), S_RUN, 1'b0);
            else       exp_out(2, "t6_done", 1'b0, 8'd2, S_DONE, 1'b1);
`endif
        end

        nxt();
        nxt();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
